sdram_cmd_arbiter: RTL and testbench
====================================

Name: sdram_cmd_arbiter

Overview:
Shares the single SDRAM controller command port between two requesters: the acquisition writer and the SPI readback reader. The acquisition writer moves baseband buffer words to SDRAM. The SPI readback reader fetches words for transmission. The block sits between those schedulers and the SDRAM controller. It enforces one outstanding command at a time, routes returned read data, and bounds read starvation under continuous acquisition.

Parameters:
SDRAM_ADDRESS_WIDTH, 22, pointer width; command address is SDRAM_ADDRESS_WIDTH-1 bits
DATA_WIDTH, 32, SDRAM word width
MAX_WR_STREAK, 8, consecutive write grants allowed while a read is pending
READ_TIMEOUT, 255, cycles to wait for read data before aborting (8-bit counter)

Ports:
bb_clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  write request; held with wr_address/wr_data until wr_ack
wr_address  in  SDRAM_ADDRESS_WIDTH-1  write address
wr_data  in  DATA_WIDTH  write data
wr_ack  out  1  one-cycle pulse: write command issued
rd_req  in  1  read request; held with rd_address until rd_ack
rd_address  in  SDRAM_ADDRESS_WIDTH-1  read address
rd_ack  out  1  one-cycle pulse: read command issued
rd_data  out  DATA_WIDTH  returned read word, valid with rd_valid
rd_valid  out  1  one-cycle pulse: rd_data valid
rd_error  out  1  one-cycle pulse: read timed out
cmd_ready  in  1  SDRAM controller can accept a command
cmd_enable  out  1  one-cycle command strobe
cmd_wr  out  1  1=write, 0=read
cmd_address  out  SDRAM_ADDRESS_WIDTH-1  command address
cmd_data_in  out  DATA_WIDTH  write data to controller
data_out  in  DATA_WIDTH  read data from controller
data_out_ready  in  1  read data valid from controller
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0, including cmd_address, cmd_data_in and rd_data. wr_streak and timeout counter cleared. An in-flight read is abandoned and no rd_valid or rd_error is produced.
- States: IDLE, WR_GAP, RD_WAIT.
- IDLE: arbitration occurs only when cmd_ready=1; with cmd_ready=0 nothing happens and both acks stay 0.
  - Read wins if rd_req=1 and either wr_req=0 or wr_streak>=MAX_WR_STREAK.
  - Otherwise write wins if wr_req=1.
- Write grant, registered on the grant edge:
  - cmd_enable=1, cmd_wr=1, cmd_address=wr_address, cmd_data_in=wr_data, wr_ack=1.
  - wr_streak increments only if rd_req=1, saturating at MAX_WR_STREAK; it is cleared when rd_req=0.
  - Next state WR_GAP.
- Read grant, registered on the grant edge:
  - cmd_enable=1, cmd_wr=0, cmd_address=rd_address, rd_ack=1.
  - cmd_data_in is unchanged; wr_streak and the timeout counter are cleared.
  - Next state RD_WAIT.
- WR_GAP: cmd_enable=0, wr_ack=0; unconditionally returns to IDLE. Write throughput is therefore at most one per 2 cycles.
- RD_WAIT: cmd_enable=0, rd_ack=0.
  - On data_out_ready=1: rd_data<=data_out, rd_valid=1 for one cycle, return to IDLE.
  - Otherwise the counter increments. When it reaches READ_TIMEOUT: rd_error=1 for one cycle, rd_data unchanged, return to IDLE.
  - If data_out_ready arrives in the same cycle the count reaches READ_TIMEOUT, data wins: rd_valid=1, rd_error=0.
- data_out_ready outside RD_WAIT is ignored; rd_data is not updated.
- Requesters may drop req the cycle after ack or keep it high for back-to-back transactions. Ack is never issued for a req that deasserted before the grant edge.
- cmd_enable is never high on two consecutive cycles; cmd_wr and cmd_address stay stable until the next grant.
- Latency: grant edge to cmd_enable high = 0 cycles (registered outputs). rd_valid follows data_out_ready by 1 cycle.

Decomposition:
- Shared package: state encodings, and a MAX_WR_STREAK default matching the scheduler's burst size.
- One sub-module is natural: sdram_rd_timeout (8-bit load/count/expire counter). Everything else stays in the arbiter.

Test Plan:
- Write-only: wr_req held, cmd_ready=1, wr_address=0x000010, wr_data=0xDEADBEEF -> wr_ack and cmd_enable every 2nd cycle, cmd_wr=1, cmd_address=0x000010, cmd_data_in=0xDEADBEEF.
- Read: rd_req with rd_address=0x1FFFFF; data_out=0x12345678 with data_out_ready 5 cycles after rd_ack -> rd_valid one cycle later, rd_data=0x12345678, busy low afterwards.
- Starvation bound: wr_req and rd_req both held continuously, MAX_WR_STREAK=8 -> exactly 8 write grants, then 1 read grant, repeating.
- Timeout: read granted, no data_out_ready -> rd_error pulses at cycle 255 in RD_WAIT; a late data_out_ready afterwards leaves rd_data unchanged. Separately, data_out_ready in the expiry cycle -> rd_valid=1, rd_error=0.
- cmd_ready low: requests pending with cmd_ready=0 for 10 cycles -> no cmd_enable and no ack; grant occurs on the first cycle cmd_ready=1.
- Reset mid-read: rst_n pulsed low in RD_WAIT -> all outputs 0 immediately, then data_out_ready produces no rd_valid and state is IDLE.

Source files
------------

// File: rtl/sdram_cmd_arbiter_pkg.sv
// ============================================================================
// Module      : sdram_cmd_arbiter_pkg
// Description : Shared state encoding and defaults for the SDRAM command arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_cmd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_GAP  = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_t;

    // Matches the acquisition scheduler's burst size.
    localparam int unsigned DEFAULT_MAX_WR_STREAK = 8;
    localparam int unsigned DEFAULT_READ_TIMEOUT  = 255;
    localparam int unsigned TIMEOUT_CNT_WIDTH     = 8;

endpackage : sdram_cmd_arbiter_pkg

`default_nettype wire

// File: rtl/sdram_cmd_arbiter_if.sv
// ============================================================================
// Module      : sdram_cmd_arbiter_if
// Description : Requester and SDRAM-controller signals seen by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_cmd_arbiter_if #(
    parameter int unsigned SDRAM_ADDRESS_WIDTH = 22,
    parameter int unsigned DATA_WIDTH          = 32
);

    logic                           wr_req;
    logic [SDRAM_ADDRESS_WIDTH-2:0] wr_address;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           wr_ack;

    logic                           rd_req;
    logic [SDRAM_ADDRESS_WIDTH-2:0] rd_address;
    logic                           rd_ack;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic                           rd_valid;
    logic                           rd_error;

    logic                           cmd_ready;
    logic                           cmd_enable;
    logic                           cmd_wr;
    logic [SDRAM_ADDRESS_WIDTH-2:0] cmd_address;
    logic [DATA_WIDTH-1:0]          cmd_data_in;
    logic [DATA_WIDTH-1:0]          data_out;
    logic                           data_out_ready;

    logic                           busy;

    // Arbiter side: masters the controller command port.
    modport master (
        input  wr_req, wr_address, wr_data,
        output wr_ack,
        input  rd_req, rd_address,
        output rd_ack, rd_data, rd_valid, rd_error,
        input  cmd_ready, data_out, data_out_ready,
        output cmd_enable, cmd_wr, cmd_address, cmd_data_in,
        output busy
    );

    // Environment side: requesters plus the SDRAM controller.
    modport slave (
        output wr_req, wr_address, wr_data,
        input  wr_ack,
        output rd_req, rd_address,
        input  rd_ack, rd_data, rd_valid, rd_error,
        output cmd_ready, data_out, data_out_ready,
        input  cmd_enable, cmd_wr, cmd_address, cmd_data_in,
        input  busy
    );

endinterface : sdram_cmd_arbiter_if

`default_nettype wire

// File: rtl/sdram_rd_timeout.sv
// ============================================================================
// Module      : sdram_rd_timeout
// Description : Load/count/expire counter bounding the wait for read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_rd_timeout
    import sdram_cmd_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_READ_TIMEOUT,
    parameter int unsigned WIDTH   = TIMEOUT_CNT_WIDTH
) (
    input  wire logic bb_clk,
    input  wire logic rst_n,
    input  wire logic load_i,
    input  wire logic count_i,
    output logic      expire_o
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Expires on the increment that brings the count to TIMEOUT.
    assign expire_o = count_i && (cnt_q == C_LAST);

    always_ff @(posedge bb_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sdram_rd_timeout

`default_nettype wire

// File: rtl/sdram_cmd_arbiter.sv
// ============================================================================
// Module      : sdram_cmd_arbiter
// Description : Arbitrates the SDRAM command port between writer and reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_cmd_arbiter
    import sdram_cmd_arbiter_pkg::*;
#(
    parameter int unsigned SDRAM_ADDRESS_WIDTH = 22,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned MAX_WR_STREAK       = DEFAULT_MAX_WR_STREAK,
    parameter int unsigned READ_TIMEOUT        = DEFAULT_READ_TIMEOUT
) (
    input  wire logic           bb_clk,
    input  wire logic           rst_n,
    sdram_cmd_arbiter_if.master bus
);

    localparam int unsigned AW       = SDRAM_ADDRESS_WIDTH - 1;
    localparam int unsigned STREAK_W = $clog2(MAX_WR_STREAK + 1);
    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

    arb_state_t            state_q,       state_d;
    logic [STREAK_W-1:0]   streak_q,      streak_d;
    logic                  cmd_enable_q,  cmd_enable_d;
    logic                  cmd_wr_q,      cmd_wr_d;
    logic [AW-1:0]         cmd_address_q, cmd_address_d;
    logic [DATA_WIDTH-1:0] cmd_data_q,    cmd_data_d;
    logic                  wr_ack_q,      wr_ack_d;
    logic                  rd_ack_q,      rd_ack_d;
    logic [DATA_WIDTH-1:0] rd_data_q,     rd_data_d;
    logic                  rd_valid_q,    rd_valid_d;
    logic                  rd_error_q,    rd_error_d;

    logic tmo_load;
    logic tmo_count;
    logic tmo_expire;
    logic rd_wins;

    sdram_rd_timeout #(
        .TIMEOUT (READ_TIMEOUT),
        .WIDTH   (TIMEOUT_CNT_WIDTH)
    ) u_rd_timeout (
        .bb_clk   (bb_clk),
        .rst_n    (rst_n),
        .load_i   (tmo_load),
        .count_i  (tmo_count),
        .expire_o (tmo_expire)
    );

    // A pending read preempts writes once the write streak is exhausted.
    assign rd_wins = bus.rd_req && (!bus.wr_req || (streak_q >= C_STREAK_MAX));

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        cmd_enable_d  = 1'b0;
        cmd_wr_d      = cmd_wr_q;
        cmd_address_d = cmd_address_q;
        cmd_data_d    = cmd_data_q;
        wr_ack_d      = 1'b0;
        rd_ack_d      = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        rd_error_d    = 1'b0;
        tmo_load      = 1'b0;
        tmo_count     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_ready) begin
                    if (rd_wins) begin
                        cmd_enable_d  = 1'b1;
                        cmd_wr_d      = 1'b0;
                        cmd_address_d = bus.rd_address;
                        rd_ack_d      = 1'b1;
                        streak_d      = '0;
                        tmo_load      = 1'b1;
                        state_d       = ST_RD_WAIT;
                    end else if (bus.wr_req) begin
                        cmd_enable_d  = 1'b1;
                        cmd_wr_d      = 1'b1;
                        cmd_address_d = bus.wr_address;
                        cmd_data_d    = bus.wr_data;
                        wr_ack_d      = 1'b1;
                        if (!bus.rd_req) begin
                            streak_d = '0;
                        end else if (streak_q < C_STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                        state_d = ST_WR_GAP;
                    end
                end
            end
            ST_WR_GAP: begin
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                // Data in the expiry cycle takes priority over the timeout.
                if (bus.data_out_ready) begin
                    rd_data_d  = bus.data_out;
                    rd_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmo_count = 1'b1;
                    if (tmo_expire) begin
                        rd_error_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            streak_q      <= '0;
            cmd_enable_q  <= 1'b0;
            cmd_wr_q      <= 1'b0;
            cmd_address_q <= '0;
            cmd_data_q    <= '0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            cmd_enable_q  <= cmd_enable_d;
            cmd_wr_q      <= cmd_wr_d;
            cmd_address_q <= cmd_address_d;
            cmd_data_q    <= cmd_data_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            rd_error_q    <= rd_error_d;
        end
    end

    assign bus.cmd_enable  = cmd_enable_q;
    assign bus.cmd_wr      = cmd_wr_q;
    assign bus.cmd_address = cmd_address_q;
    assign bus.cmd_data_in = cmd_data_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.rd_ack      = rd_ack_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_error    = rd_error_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule : sdram_cmd_arbiter

`default_nettype wire

// File: tb/tb_sdram_cmd_arbiter.sv
// ============================================================================
// Module      : tb_sdram_cmd_arbiter
// Description : Directed self-checking bench for sdram_cmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_cmd_arbiter;

    logic bb_clk = 1'b0;
    logic rst_n  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    sdram_cmd_arbiter_if #(.SDRAM_ADDRESS_WIDTH(22), .DATA_WIDTH(32)) bus ();

    sdram_cmd_arbiter #(
        .SDRAM_ADDRESS_WIDTH (22),
        .DATA_WIDTH          (32),
        .MAX_WR_STREAK       (8),
        .READ_TIMEOUT        (255)
    ) u_dut (
        .bb_clk (bb_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 bb_clk = ~bb_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge bb_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants;
        int viol;
        int err_at;
        logic prev_en;
        logic seen;

        bus.wr_req         = 1'b0;
        bus.wr_address     = '0;
        bus.wr_data        = '0;
        bus.rd_req         = 1'b0;
        bus.rd_address     = '0;
        bus.cmd_ready      = 1'b0;
        bus.data_out       = '0;
        bus.data_out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_busy",    bus.busy,        0);
        check_val("rst_cmd_en",  bus.cmd_enable,  0);
        check_val("rst_cmd_adr", bus.cmd_address, 0);
        check_val("rst_rd_data", bus.rd_data,     0);
        rst_n = 1'b1;
        tick();

        // Write-only stream: a grant every second cycle
        bus.cmd_ready  = 1'b1;
        bus.wr_req     = 1'b1;
        bus.wr_address = 21'h000010;
        bus.wr_data    = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val($sformatf("wr_en%0d", i),  bus.cmd_enable, (i % 2 == 0));
            check_val($sformatf("wr_ack%0d", i), bus.wr_ack,     (i % 2 == 0));
            if (i == 4) begin
                check_val("wr_cmd_wr",  bus.cmd_wr,      1);
                check_val("wr_cmd_adr", bus.cmd_address, 21'h000010);
                check_val("wr_cmd_dat", bus.cmd_data_in, 32'hDEADBEEF);
                bus.wr_req = 1'b0;
            end
        end

        // Single read with data five cycles after the ack
        bus.rd_req     = 1'b1;
        bus.rd_address = 21'h1FFFFF;
        bus.data_out   = 32'h12345678;
        tick();
        check_val("rd_ack",      bus.rd_ack,      1);
        check_val("rd_cmd_en",   bus.cmd_enable,  1);
        check_val("rd_cmd_wr",   bus.cmd_wr,      0);
        check_val("rd_cmd_adr",  bus.cmd_address, 21'h1FFFFF);
        check_val("rd_keep_dat", bus.cmd_data_in, 32'hDEADBEEF);
        bus.rd_req = 1'b0;
        tick();
        check_val("rd_ack_pulse", bus.rd_ack,     0);
        check_val("rd_en_pulse",  bus.cmd_enable, 0);
        check_val("rd_busy",      bus.busy,       1);
        for (int i = 0; i < 3; i++) tick();
        check_val("rd_no_valid",  bus.rd_valid,   0);
        bus.data_out_ready = 1'b1;
        tick();
        check_val("rd_valid",     bus.rd_valid,   1);
        check_val("rd_data",      bus.rd_data,    32'h12345678);
        check_val("rd_idle",      bus.busy,       0);
        bus.data_out_ready = 1'b0;
        tick();
        check_val("rd_valid_pulse", bus.rd_valid, 0);

        // Starvation bound: 8 writes then 1 read, repeating
        bus.wr_req         = 1'b1;
        bus.rd_req         = 1'b1;
        bus.data_out       = 32'hCAFEF00D;
        bus.data_out_ready = 1'b1;
        grants  = 0;
        viol    = 0;
        prev_en = 1'b0;
        for (int c = 0; c < 60 && grants < 27; c++) begin
            tick();
            if (bus.cmd_enable) begin
                if (prev_en) viol++;
                check_val($sformatf("starve_g%0d", grants), bus.cmd_wr, (grants % 9 != 8));
                grants++;
            end
            prev_en = bus.cmd_enable;
        end
        check_val("starve_grants", grants, 27);
        check_val("starve_b2b",    viol,   0);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        tick();
        bus.data_out_ready = 1'b0;
        tick();
        check_val("starve_idle", bus.busy,    0);
        check_val("starve_data", bus.rd_data, 32'hCAFEF00D);

        // Timeout without data, then a late data_out_ready
        bus.data_out   = 32'h55AA55AA;
        bus.rd_address = 21'h000123;
        bus.rd_req     = 1'b1;
        tick();
        check_val("to_ack", bus.rd_ack, 1);
        bus.rd_req = 1'b0;
        err_at = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (bus.rd_valid) seen = 1'b1;
            if (bus.rd_error) begin
                err_at = k;
                break;
            end
        end
        check_val("to_cycle",    err_at,       255);
        check_val("to_no_valid", seen,         0);
        check_val("to_data",     bus.rd_data,  32'hCAFEF00D);
        check_val("to_idle",     bus.busy,     0);
        tick();
        check_val("to_err_pulse", bus.rd_error, 0);
        bus.data_out_ready = 1'b1;
        tick();
        check_val("late_valid", bus.rd_valid, 0);
        check_val("late_data",  bus.rd_data,  32'hCAFEF00D);
        bus.data_out_ready = 1'b0;
        tick();

        // Data arriving in the expiry cycle wins over the timeout
        bus.data_out = 32'h0BADCAFE;
        bus.rd_req   = 1'b1;
        tick();
        check_val("exp_ack", bus.rd_ack, 1);
        bus.rd_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 254; k++) begin
            tick();
            if (bus.rd_valid || bus.rd_error) seen = 1'b1;
        end
        check_val("exp_quiet", seen, 0);
        bus.data_out_ready = 1'b1;
        tick();
        check_val("exp_valid", bus.rd_valid, 1);
        check_val("exp_error", bus.rd_error, 0);
        check_val("exp_data",  bus.rd_data,  32'h0BADCAFE);
        bus.data_out_ready = 1'b0;
        tick();

        // cmd_ready low holds off arbitration
        bus.cmd_ready  = 1'b0;
        bus.wr_req     = 1'b1;
        bus.rd_req     = 1'b1;
        bus.wr_address = 21'h000ABC;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.cmd_enable || bus.wr_ack || bus.rd_ack) seen = 1'b1;
        end
        check_val("cr_quiet", seen,     0);
        check_val("cr_busy",  bus.busy, 0);
        bus.cmd_ready = 1'b1;
        tick();
        check_val("cr_en",     bus.cmd_enable,  1);
        check_val("cr_wr_ack", bus.wr_ack,      1);
        check_val("cr_rd_ack", bus.rd_ack,      0);
        check_val("cr_adr",    bus.cmd_address, 21'h000ABC);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        tick();

        // Asynchronous reset during RD_WAIT
        bus.rd_req     = 1'b1;
        bus.rd_address = 21'h0F0F0F;
        tick();
        check_val("mr_ack", bus.rd_ack, 1);
        bus.rd_req = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mr_busy",    bus.busy,        0);
        check_val("mr_cmd_adr", bus.cmd_address, 0);
        check_val("mr_cmd_dat", bus.cmd_data_in, 0);
        check_val("mr_rd_data", bus.rd_data,     0);
        check_val("mr_cmd_wr",  bus.cmd_wr,      0);
        #1;
        rst_n = 1'b1;
        bus.data_out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.rd_valid || bus.rd_error) seen = 1'b1;
        end
        check_val("mr_no_valid", seen,        0);
        check_val("mr_idle",     bus.busy,    0);
        check_val("mr_data",     bus.rd_data, 0);
        bus.data_out_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sdram_cmd_arbiter

`default_nettype wire
